status_led_driver: RTL and testbench

Consumes the 2-bit status code from the startup/output test state machine and drives one board LED with a distinct pattern per code: off, solid, slow blink or fast blink.
- A short-glitch filter rejects unstable codes.
- A minimum-display hold makes every adopted code visible for a fixed time.
- Sits directly downstream of the status FSM; its output goes straight to the LED pin.

---
 rtl/status_led_driver_pkg.sv | 27 ++
 rtl/status_led_driver_tick_prescaler.sv | 32 +++
 rtl/status_led_driver.sv | 128 ++++++++++++
 tb/tb_status_led_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/status_led_driver_pkg.sv
// Shared status-code definitions for the status LED path.
// The upstream startup/output test FSM produces these codes and
// status_led_driver turns each one into a visible LED pattern.
//   STATUS_OFF  : LED dark
//   STATUS_ON   : LED solid on
//   STATUS_SLOW : slow blink
//   STATUS_FAST : fast blink
package status_led_driver_pkg;

  typedef enum logic [1:0] {
    STATUS_OFF  = 2'h0,
    STATUS_ON   = 2'h1,
    STATUS_SLOW = 2'h2,
    STATUS_FAST = 2'h3
  } status_code_t;

  // LED level for a displayed code; the blinking codes simply show the
  // current blink phase.
  function automatic logic led_level(input status_code_t code, input logic phase);
    case (code)
      STATUS_OFF: return 1'b0;
      STATUS_ON:  return 1'b1;
      default:    return phase;
    endcase
  endfunction

endpackage

// File: rtl/status_led_driver_tick_prescaler.sv
// tick_prescaler: free-running divider that emits a one-cycle tick every
// DIV clock cycles. Kept generic so it can also pace a UART bit clock.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset, clears the count
//   tick    : high for one clk cycle when the count reaches DIV-1
module tick_prescaler #(
  parameter int DIV = 12000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap on the tick cycle; nothing else restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/status_led_driver.sv
// status_led_driver: turns the 2-bit status code of the upstream FSM into
// an LED pattern (off / solid / slow blink / fast blink). Codes must be
// stable for STABLE_CYCLES clocks before they are adopted, and an adopted
// code stays on display for at least HOLD_TICKS ticks.
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   status       : status code from the upstream FSM (same clock domain)
//   led          : LED drive, active-high, registered
//   status_shown : code currently on display, registered
//   busy         : high while the minimum-display hold is running
module status_led_driver
  import status_led_driver_pkg::*;
#(
  parameter int TICK_DIV      = 12000,
  parameter int HOLD_TICKS    = 250,
  parameter int SLOW_TICKS    = 500,
  parameter int FAST_TICKS    = 100,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] status,
  output logic       led,
  output logic [1:0] status_shown,
  output logic       busy
);

  // A zero hold still needs a one-bit counter.
  localparam int HOLD_W    = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int STAB_W    = $clog2(STABLE_CYCLES + 1);
  localparam int BLINK_MAX = (SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS;
  localparam int BLINK_W   = $clog2(BLINK_MAX + 1);

  logic               tick;
  status_code_t       status_q;
  status_code_t       shown_q;
  logic [STAB_W-1:0]  stable_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_nxt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] period_m1;
  logic               phase;
  logic               candidate_valid;
  logic               adopt;

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign status_shown    = shown_q;
  assign candidate_valid = (stable_cnt == STAB_W'(STABLE_CYCLES));
  assign adopt           = candidate_valid && (status_q != shown_q) && (hold_cnt == '0);
  assign period_m1       = (shown_q == STATUS_FAST) ? BLINK_W'(FAST_TICKS - 1)
                                                    : BLINK_W'(SLOW_TICKS - 1);

  // Input register plus stability counter: any change restarts the count,
  // otherwise it climbs and parks at STABLE_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q   <= STATUS_OFF;
      stable_cnt <= '0;
    end else begin
      status_q <= status_code_t'(status);
      if (status != status_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt != STAB_W'(STABLE_CYCLES)) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  // Next hold value; an adoption reloads it even on a tick cycle.
  always_comb begin
    hold_nxt = hold_cnt;
    if (adopt) begin
      hold_nxt = HOLD_W'(HOLD_TICKS);
    end else if (tick && (hold_cnt != '0)) begin
      hold_nxt = hold_cnt - 1'b1;
    end
  end

  // busy is registered alongside the hold counter so both change together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      busy     <= (hold_nxt != '0);
    end
  end

  // Display state: adoption starts every blinking code in its "on" phase;
  // non-blinking codes keep the blink machinery parked at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shown_q   <= STATUS_OFF;
      blink_cnt <= '0;
      phase     <= 1'b0;
      led       <= 1'b0;
    end else begin
      led <= led_level(shown_q, phase);
      if (adopt) begin
        shown_q   <= status_q;
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if ((shown_q == STATUS_SLOW) || (shown_q == STATUS_FAST)) begin
        if (tick) begin
          if (blink_cnt == period_m1) begin
            blink_cnt <= '0;
            phase     <= ~phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end else begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_status_led_driver.sv
// Self-checking bench for status_led_driver with small parameters.
// Every negedge the observed {led, status_shown, busy} is compared with the
// value a reference model queued when the stimulus for that edge was driven;
// directed checks cover latency, blink periods, the hold window and reset.
module tb_status_led_driver;

  localparam int TICK_DIV      = 4;
  localparam int HOLD_TICKS    = 3;
  localparam int SLOW_TICKS    = 4;
  localparam int FAST_TICKS    = 2;
  localparam int STABLE_CYCLES = 2;

  logic       clk;
  logic       reset_n;
  logic [1:0] status;
  logic       led;
  logic [1:0] status_shown;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [3:0] exp_q[$];

  // Reference model state
  int m_cnt, m_q, m_stab, m_shown, m_hold, m_blink;
  bit m_phase, m_led, m_busy;

  status_led_driver #(
    .TICK_DIV     (TICK_DIV),
    .HOLD_TICKS   (HOLD_TICKS),
    .SLOW_TICKS   (SLOW_TICKS),
    .FAST_TICKS   (FAST_TICKS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .status      (status),
    .led         (led),
    .status_shown(status_shown),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @cycle %0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_q = 0; m_stab = 0; m_shown = 0; m_hold = 0; m_blink = 0;
    m_phase = 1'b0; m_led = 1'b0; m_busy = 1'b0;
  endtask

  // Advance the model by one clock edge with input s.
  task automatic model_step(input int s);
    bit tk;
    bit take;
    int period;
    tk   = (m_cnt == TICK_DIV - 1);
    take = (m_stab == STABLE_CYCLES) && (m_q != m_shown) && (m_hold == 0);
    if (m_shown == 0)      m_led = 1'b0;
    else if (m_shown == 1) m_led = 1'b1;
    else                   m_led = m_phase;
    if (take) begin
      m_shown = m_q;
      m_hold  = HOLD_TICKS;
      m_blink = 0;
      m_phase = 1'b1;
    end else begin
      if (tk && m_hold > 0) m_hold = m_hold - 1;
      if (m_shown >= 2) begin
        period = (m_shown == 3) ? FAST_TICKS : SLOW_TICKS;
        if (tk) begin
          m_blink = m_blink + 1;
          if (m_blink == period) begin
            m_blink = 0;
            m_phase = ~m_phase;
          end
        end
      end else begin
        m_blink = 0;
        m_phase = 1'b0;
      end
    end
    m_busy = (m_hold != 0);
    if (s != m_q)                   m_stab = 0;
    else if (m_stab < STABLE_CYCLES) m_stab = m_stab + 1;
    m_q   = s;
    m_cnt = tk ? 0 : m_cnt + 1;
  endtask

  // One cycle: check what the last edge produced, then drive the inputs
  // for the next edge and queue what the model predicts for it.
  task automatic applyStimulus(input logic [1:0] s, input logic r);
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) checkOutput("cycle", {led, status_shown, busy}, exp_q.pop_front());
    reset_n = r;
    status  = s;
    if (!r) model_reset();
    else    model_step(int'(s));
    exp_q.push_back({m_led, 2'(m_shown), m_busy});
  endtask

  task automatic wait_shown(input logic [1:0] s, input logic [1:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(s, 1'b1);
      if (status_shown == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Cycle distance between the 1st/2nd and 2nd/3rd LED transitions.
  task automatic measure_gaps(input logic [1:0] s, output int g1, output int g2);
    int   t[3];
    int   n;
    logic prev;
    n    = 0;
    prev = led;
    for (int i = 0; i < 200 && n < 3; i++) begin
      applyStimulus(s, 1'b1);
      if (led !== prev) begin
        t[n] = cyc;
        n++;
        prev = led;
      end
    end
    if (n == 3) begin
      g1 = t[1] - t[0];
      g2 = t[2] - t[1];
    end else begin
      g1 = 0;
      g2 = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit any, ok, bad, saw3;
    int g1, g2, bc;

    reset_n = 1'b0;
    status  = 2'd0;
    model_reset();
    repeat (3) applyStimulus(2'd0, 1'b0);

    // Idle after reset
    any = 1'b0;
    repeat (50) begin
      applyStimulus(2'd0, 1'b1);
      if (led || (status_shown != 2'd0) || busy) any = 1'b1;
    end
    checkOutput("idle_quiet", 4'(any), 4'd0);

    // One-cycle glitch is rejected
    applyStimulus(2'd1, 1'b1);
    any = 1'b0;
    repeat (40) begin
      applyStimulus(2'd0, 1'b1);
      if (led || (status_shown != 2'd0)) any = 1'b1;
    end
    checkOutput("glitch_rejected", 4'(any), 4'd0);

    // Adoption latency and hold length
    applyStimulus(2'd1, 1'b1);
    repeat (3) applyStimulus(2'd1, 1'b1);
    checkOutput("shown_edge3", 4'(status_shown), 4'd0);
    applyStimulus(2'd1, 1'b1);
    checkOutput("shown_edge4", 4'(status_shown), 4'd1);
    checkOutput("led_edge4", 4'(led), 4'd0);
    bc = int'(busy);
    applyStimulus(2'd1, 1'b1);
    checkOutput("led_edge5", 4'(led), 4'd1);
    bc += int'(busy);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'd1, 1'b1);
      if (!busy) break;
      bc++;
    end
    checkOutput("busy_len_8_12", 4'((bc >= 8) && (bc <= 12)), 4'd1);

    // Slow blink
    wait_shown(2'd2, 2'd2, ok);
    checkOutput("adopt_slow", 4'(ok), 4'd1);
    applyStimulus(2'd2, 1'b1);
    checkOutput("slow_first_phase", 4'(led), 4'd1);
    measure_gaps(2'd2, g1, g2);
    checkOutput("slow_gap1", 4'(g1), 4'd0 + 4'(16 % 16));
    checkOutput("slow_gap1_full", 4'(g1 / 16), 4'd1);
    checkOutput("slow_gap2", 4'(g2 == 16), 4'd1);

    // Fast blink
    wait_shown(2'd3, 2'd3, ok);
    checkOutput("adopt_fast", 4'(ok), 4'd1);
    applyStimulus(2'd3, 1'b1);
    checkOutput("fast_first_phase", 4'(led), 4'd1);
    measure_gaps(2'd3, g1, g2);
    checkOutput("fast_gap1", 4'(g1), 4'd8);
    checkOutput("fast_gap2", 4'(g2), 4'd8);

    // Changes during hold: 3 then 2, only 2 is adopted at expiry
    wait_shown(2'd1, 2'd1, ok);
    checkOutput("adopt_on", 4'(ok), 4'd1);
    bad  = 1'b0;
    saw3 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i < 3) ? 2'd3 : 2'd2, 1'b1);
      if (status_shown == 2'd3) saw3 = 1'b1;
      if (busy && (status_shown != 2'd1)) bad = 1'b1;
      if (!busy) break;
    end
    checkOutput("hold_busy_fell", 4'(busy), 4'd0);
    checkOutput("hold_shown_kept", 4'(status_shown), 4'd1);
    checkOutput("hold_no_change", 4'(bad), 4'd0);
    applyStimulus(2'd2, 1'b1);
    checkOutput("expiry_adopt", 4'(status_shown), 4'd2);
    checkOutput("dropped_fast", 4'(saw3), 4'd0);

    // Asynchronous reset mid-blink
    repeat (20) applyStimulus(2'd2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (led) break;
      applyStimulus(2'd2, 1'b1);
    end
    checkOutput("led_on_before_reset", 4'(led), 4'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", {led, status_shown, busy}, 4'd0);
    exp_q.delete();
    model_reset();
    repeat (3) applyStimulus(2'd2, 1'b0);
    wait_shown(2'd1, 2'd1, ok);
    checkOutput("resume_after_reset", 4'(ok), 4'd1);
    repeat (20) applyStimulus(2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
